weight_memory_compute_address_sequencer: RTL
============================================

Name: weight_memory_compute_address_sequencer

Overview:
Sequences weight-buffer reads during compute. For each PE array in a row it generates the read address of the weight memory compute port. Array 0 is driven first; array i follows the same address stream delayed by i cycles, which gives the systolic skew. A single start/done handshake configures and runs one layer: a weight window that repeats for a programmed number of passes, with global stall support.

Parameters:
WEIGHT_BANK_DEPTH, 8, words per weight bank; ADDR_W = $clog2(WEIGHT_BANK_DEPTH)
NUMBER_OF_PE_ARRAYS_PER_ROW, 8, number of PE arrays receiving skewed addresses
COUNT_WIDTH, 16, width of the weights_per_pass and number_of_passes config fields

Ports:
clk  input  1  clock, rising edge
resetn  input  1  reset, synchronous, active-low
start  input  1  begin a run; sampled only in IDLE
start_address  input  ADDR_W  first weight word of each pass
weights_per_pass  input  COUNT_WIDTH  addresses per pass
number_of_passes  input  COUNT_WIDTH  repetitions of the window
stall  input  1  freezes all sequencing while high
compute_address  output  ADDR_W x NUMBER_OF_PE_ARRAYS_PER_ROW (unpacked array)  read address per PE array
compute_address_valid  output  NUMBER_OF_PE_ARRAYS_PER_ROW  per-array address valid
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse at run completion

Behaviour:
- Reset (resetn=0 at a clk edge):
  - State goes to IDLE; all counters and the skew pipeline clear.
  - compute_address all 0, compute_address_valid 0, busy 0, done 0.
  - Reset mid-run aborts the run; no done pulse is produced.
- Config latch: start_address, weights_per_pass and number_of_passes are registered when start is accepted. Later input changes have no effect on the current run.
- States:
  - IDLE: on start=1, go to RUN. If weights_per_pass==0 or number_of_passes==0, go to DONE instead.
  - RUN: each unstalled cycle, array 0 gets address = start_address + offset, with a valid. The sum is truncated to ADDR_W, so it wraps modulo WEIGHT_BANK_DEPTH. offset runs 0..weights_per_pass-1, then returns to 0 and increments the pass counter. After the last address of the last pass, go to DRAIN.
  - DRAIN: lasts NUMBER_OF_PE_ARRAYS_PER_ROW-1 unstalled cycles while the skew pipeline empties. With NUMBER_OF_PE_ARRAYS_PER_ROW=1 it is skipped. Then go to DONE.
  - DONE: done=1 for exactly one cycle, busy falls, next state IDLE.
- Skew pipeline:
  - Array i output = array i-1 output (address and valid) registered one cycle earlier.
  - All stages are registers. Array 0 is registered from the generator.
- Latency:
  - Array 0's first address appears the cycle after start is accepted.
  - Array i's first address appears i cycles later.
  - done is asserted the cycle after array N-1's last valid.
  - Unstalled run length from accept to done = weights_per_pass*number_of_passes + NUMBER_OF_PE_ARRAYS_PER_ROW.
- Stall:
  - While stall=1, the state, counters and all skew stages hold their values; outputs are held unchanged, including valids.
  - Stall in IDLE does not block start acceptance.
  - Stall in DONE does not delay the done pulse.
- start while busy is ignored. start in the same cycle done is high is ignored; it must be re-asserted in IDLE.
- Counter width: the pass and offset counters are COUNT_WIDTH bits. The total address count is not limited to the bank depth, because the address wraps.
- Valids outside RUN/DRAIN are 0 for every array. Addresses keep their last value when not valid.

Test Plan:
- Reset mid-RUN → next cycle all valids 0, busy 0, addresses 0; no done pulse.
- Basic wrap (NUMBER_OF_PE_ARRAYS_PER_ROW=4, DEPTH=8): start at cycle 0 with start_address=6, weights_per_pass=3, number_of_passes=2 →
  - array0 sees 6,7,0,6,7,0 in cycles 1-6;
  - array3 sees the same sequence in cycles 4-9;
  - done at cycle 10; busy in cycles 1-10.
- Stall: same config, stall=1 in cycles 3-4 → all outputs frozen in cycles 3-4; every later event shifts by 2; done at cycle 12.
- Zero config: weights_per_pass=0, number_of_passes=5 → no valid ever asserted; done at cycle 1; return to IDLE.
- start held high continuously, with the run from the basic-wrap test → the second run is accepted at cycle 11, not at cycle 10; no overlap of valids between runs.
- Config change: start_address changed to 2 in cycle 2 of a run with start_address=6 → the running sequence is still 6,7,0,...

Source files
------------

// File: rtl/weight_memory_compute_address_sequencer_if.sv
// weight_memory_compute_address_sequencer_if: run control plus per-PE-array skewed weight read addresses
interface weight_memory_compute_address_sequencer_if #(
   parameter int WEIGHT_BANK_DEPTH = 8,
   parameter int NUMBER_OF_PE_ARRAYS_PER_ROW = 8,
   parameter int COUNT_WIDTH = 16
);
   localparam int ADDR_W = WEIGHT_BANK_DEPTH > 1 ? $clog2(WEIGHT_BANK_DEPTH) : 1;
   logic start;
   logic [ADDR_W-1:0] start_address;
   logic [COUNT_WIDTH-1:0] weights_per_pass;
   logic [COUNT_WIDTH-1:0] number_of_passes;
   logic stall;
   logic [ADDR_W-1:0] compute_address [NUMBER_OF_PE_ARRAYS_PER_ROW];
   logic [NUMBER_OF_PE_ARRAYS_PER_ROW-1:0] compute_address_valid;
   logic busy;
   logic done;
   modport master (
      output start, start_address, weights_per_pass, number_of_passes, stall,
      input compute_address, compute_address_valid, busy, done
   );
   modport slave (
      input start, start_address, weights_per_pass, number_of_passes, stall,
      output compute_address, compute_address_valid, busy, done
   );
endinterface

// File: rtl/weight_memory_compute_address_sequencer.sv
// weight_memory_compute_address_sequencer: repeats a weight address window per pass and skews it across PE arrays
module weight_memory_compute_address_sequencer #(
   parameter int WEIGHT_BANK_DEPTH = 8,
   parameter int NUMBER_OF_PE_ARRAYS_PER_ROW = 8,
   parameter int COUNT_WIDTH = 16
) (
   input logic clk,
   input logic resetn,
   weight_memory_compute_address_sequencer_if.slave bus
);
   localparam int ADDR_W = WEIGHT_BANK_DEPTH > 1 ? $clog2(WEIGHT_BANK_DEPTH) : 1;
   localparam int N = NUMBER_OF_PE_ARRAYS_PER_ROW;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] addr [N];
   logic [N-1:0] valid;
   logic [COUNT_WIDTH-1:0] wpp, np, offset, pass, drain, next_offset;
   logic busy, done, last;
   assign last = offset == wpp - 1'b1 && pass == np - 1'b1;
   assign next_offset = offset == wpp - 1'b1 ? '0 : offset + 1'b1;
   assign bus.compute_address = addr;
   assign bus.compute_address_valid = valid;
   assign bus.busy = busy;
   assign bus.done = done;
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         base <= '0;
         wpp <= '0;
         np <= '0;
         offset <= '0;
         pass <= '0;
         drain <= '0;
         valid <= '0;
         addr <= '{default: '0};
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!bus.stall)
            for (int i = N - 1; i > 0; i--) begin
               valid[i] <= valid[i-1];
               addr[i] <= addr[i-1];
            end
         case (state)
            IDLE: if (bus.start) begin
               base <= bus.start_address;
               wpp <= bus.weights_per_pass;
               np <= bus.number_of_passes;
               offset <= '0;
               pass <= '0;
               busy <= 1'b1;
               if (bus.weights_per_pass == '0 || bus.number_of_passes == '0) begin
                  state <= DONE;
                  done <= 1'b1;
               end else begin
                  state <= RUN;
                  valid[0] <= 1'b1;
                  addr[0] <= bus.start_address;
               end
            end
            RUN: if (!bus.stall) begin
               if (last) begin
                  valid[0] <= 1'b0;
                  drain <= '0;
                  state <= N > 1 ? DRAIN : DONE;
                  done <= N == 1;
               end else begin
                  offset <= next_offset;
                  if (offset == wpp - 1'b1) pass <= pass + 1'b1;
                  // address wraps modulo the bank depth by truncation
                  addr[0] <= base + next_offset[ADDR_W-1:0];
               end
            end
            DRAIN: if (!bus.stall) begin
               drain <= drain + 1'b1;
               if (drain == COUNT_WIDTH'(N - 2)) begin
                  state <= DONE;
                  done <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
